aes_req_arbiter: RTL and testbench

Shares one aes256_fifo datapath between two block-stream requesters. Input blocks are granted round-robin, one 128-bit block per grant. The requester ID of each accepted block is recorded in an in-order tag FIFO, and each output block is routed back to the requester that submitted it. A drain/flush sequencer quiesces the core and pulses aes_rst. The block sits between the requester front-ends and the aes256_fifo in/out/empty/rst pins.

---
 rtl/aes_req_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_aes_req_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter
//   Shares one aes256_fifo datapath between two block-stream requesters.
//   Input blocks are granted round-robin, one 128-bit block per grant. The
//   requester ID of every accepted block is queued in an in-order tag FIFO so
//   each output block is returned to the requester that submitted it. A small
//   sequencer (RST_AES / RUN / DRAIN) quiesces the core on flush_req and
//   pulses aes_rst before resuming.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   reqN_in_valid/ready/block  requester N input block stream (N = 0, 1)
//   reqN_out_valid/ready/block requester N output block stream
//   aes_in_valid/ready/block   muxed input stream to the core
//   aes_out_valid/ready/block  output stream from the core
//   aes_fifo_empty             core holds no blocks
//   aes_rst                    registered active-high core reset
//   flush_req                  level request: drain and reset the core
//   flush_done                 one-cycle pulse when a flush completes
//   busy                       blocks in flight, or not in RUN
//   blk_cnt0/blk_cnt1          accepted-block counters (AES_ARB_STATS_EN only)
//
// Build option
//   AES_ARB_STATS_EN           adds blk_cnt0/blk_cnt1 per-requester counters
module aes_req_arbiter #(
    parameter int TAG_DEPTH = 8,
    parameter int TAG_AW    = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_in_valid,
    output logic         req0_in_ready,
    input  logic [127:0] req0_in_block,
    output logic         req0_out_valid,
    input  logic         req0_out_ready,
    output logic [127:0] req0_out_block,
    input  logic         req1_in_valid,
    output logic         req1_in_ready,
    input  logic [127:0] req1_in_block,
    output logic         req1_out_valid,
    input  logic         req1_out_ready,
    output logic [127:0] req1_out_block,
    output logic         aes_in_valid,
    input  logic         aes_in_ready,
    output logic [127:0] aes_in_block,
    input  logic         aes_out_valid,
    output logic         aes_out_ready,
    input  logic [127:0] aes_out_block,
    input  logic         aes_fifo_empty,
    output logic         aes_rst,
    input  logic         flush_req,
    output logic         flush_done,
    output logic         busy
`ifdef AES_ARB_STATS_EN
    ,
    output logic [31:0]  blk_cnt0,
    output logic [31:0]  blk_cnt1
`endif
);

    typedef enum logic [1:0] {
        RST_AES = 2'd0,
        RUN     = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam logic [TAG_AW:0] COUNT_FULL = (TAG_AW + 1)'(TAG_DEPTH);

    state_t             state;
    state_t             next_state;

    logic               rr_last;
    logic               hold_q;
    logic               hold_id;
    logic               flush_armed;
    logic               from_drain;

    logic               tag_mem [TAG_DEPTH];
    logic [TAG_AW-1:0]  wr_ptr;
    logic [TAG_AW-1:0]  rd_ptr;
    logic [TAG_AW:0]    count;

    logic               rr_pick;
    logic               gnt_id;
    logic               gnt_valid;
    logic               head;
    logic               has_head;
    logic               push;
    logic               pop;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            RST_AES: next_state = RUN;
            RUN:     if (flush_req && flush_armed) next_state = DRAIN;
            DRAIN:   if ((count == '0) && aes_fifo_empty) next_state = RST_AES;
            default: next_state = RST_AES;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RST_AES;
            aes_rst     <= 1'b1;
            from_drain  <= 1'b0;
            flush_done  <= 1'b0;
            flush_armed <= 1'b1;
        end else begin
            state       <= next_state;
            aes_rst     <= (next_state == RST_AES);
            // from_drain is high only during an RST_AES cycle reached via DRAIN
            from_drain  <= (state == DRAIN) && (next_state == RST_AES);
            flush_done  <= (state == RST_AES) && from_drain;
            // A level flush_req must be seen low before it can start another flush
            if (!flush_req)
                flush_armed <= 1'b1;
            else if ((state == RUN) && (next_state == DRAIN))
                flush_armed <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Input arbitration
    // ------------------------------------------------------------------
    always_comb begin
        rr_pick = (req0_in_valid && req1_in_valid) ? ~rr_last : req1_in_valid;
        // A stalled offer keeps its grant so valid/data stay stable to the core
        gnt_id        = hold_q ? hold_id : rr_pick;
        gnt_valid     = gnt_id ? req1_in_valid : req0_in_valid;
        aes_in_valid  = gnt_valid && (state == RUN) && (count != COUNT_FULL);
        aes_in_block  = gnt_id ? req1_in_block : req0_in_block;
        push          = aes_in_valid && aes_in_ready;
        req0_in_ready = push && !gnt_id;
        req1_in_ready = push && gnt_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
            hold_q  <= 1'b0;
            hold_id <= 1'b0;
        end else begin
            hold_q  <= aes_in_valid && !aes_in_ready;
            hold_id <= gnt_id;
            if (push)
                rr_last <= gnt_id;
        end
    end

    // ------------------------------------------------------------------
    // Tag FIFO and output routing
    // ------------------------------------------------------------------
    always_comb begin
        has_head       = (count != '0);
        head           = tag_mem[rd_ptr];
        aes_out_ready  = has_head && (head ? req1_out_ready : req0_out_ready);
        req0_out_valid = has_head && !head && aes_out_valid;
        req1_out_valid = has_head && head && aes_out_valid;
        req0_out_block = aes_out_block;
        req1_out_block = aes_out_block;
        pop            = aes_out_valid && aes_out_ready;
        busy           = has_head || (state != RUN);
    end

    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr] <= gnt_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (state == RST_AES) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + TAG_AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + TAG_AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (TAG_AW + 1)'(1);
                2'b01:   count <= count - (TAG_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef AES_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Per-requester accepted-block counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt0 <= '0;
            blk_cnt1 <= '0;
        end else if (state == RST_AES) begin
            blk_cnt0 <= '0;
            blk_cnt1 <= '0;
        end else begin
            if (push && !gnt_id)
                blk_cnt0 <= blk_cnt0 + 32'd1;
            if (push && gnt_id)
                blk_cnt1 <= blk_cnt1 + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb_aes_req_arbiter
//   Directed bench for aes_req_arbiter. The core pins are driven directly by
//   the bench so every arbitration, routing and sequencing decision is set up
//   and checked against hand-computed values.
module tb_aes_req_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_in_valid, req0_in_ready;
    logic [127:0] req0_in_block;
    logic         req0_out_valid, req0_out_ready;
    logic [127:0] req0_out_block;
    logic         req1_in_valid, req1_in_ready;
    logic [127:0] req1_in_block;
    logic         req1_out_valid, req1_out_ready;
    logic [127:0] req1_out_block;
    logic         aes_in_valid, aes_in_ready;
    logic [127:0] aes_in_block;
    logic         aes_out_valid, aes_out_ready;
    logic [127:0] aes_out_block;
    logic         aes_fifo_empty;
    logic         aes_rst;
    logic         flush_req;
    logic         flush_done;
    logic         busy;
`ifdef AES_ARB_STATS_EN
    logic [31:0]  blk_cnt0, blk_cnt1;
`endif

    int checks   = 0;
    int failures = 0;
    int fd_pulses = 0;
    int accepted;

    localparam logic [127:0] BLK0 = 128'h0000_0000_0000_0000_0000_0000_0000_00A0;
    localparam logic [127:0] BLK1 = 128'h0000_0000_0000_0000_0000_0000_0000_00B1;
    localparam logic [127:0] BLKO = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

    always #5 clk = ~clk;

    aes_req_arbiter #(.TAG_DEPTH(8), .TAG_AW(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0_in_valid  (req0_in_valid),
        .req0_in_ready  (req0_in_ready),
        .req0_in_block  (req0_in_block),
        .req0_out_valid (req0_out_valid),
        .req0_out_ready (req0_out_ready),
        .req0_out_block (req0_out_block),
        .req1_in_valid  (req1_in_valid),
        .req1_in_ready  (req1_in_ready),
        .req1_in_block  (req1_in_block),
        .req1_out_valid (req1_out_valid),
        .req1_out_ready (req1_out_ready),
        .req1_out_block (req1_out_block),
        .aes_in_valid   (aes_in_valid),
        .aes_in_ready   (aes_in_ready),
        .aes_in_block   (aes_in_block),
        .aes_out_valid  (aes_out_valid),
        .aes_out_ready  (aes_out_ready),
        .aes_out_block  (aes_out_block),
        .aes_fifo_empty (aes_fifo_empty),
        .aes_rst        (aes_rst),
        .flush_req      (flush_req),
        .flush_done     (flush_done),
        .busy           (busy)
`ifdef AES_ARB_STATS_EN
        ,
        .blk_cnt0       (blk_cnt0),
        .blk_cnt1       (blk_cnt1)
`endif
    );

    always @(negedge clk) if (flush_done) fd_pulses++;

    typedef struct packed {
        logic v0, v1, ir, ov, or0, or1;
        logic g, aiv, rdy0, rdy1, aor, ov0, ov1, bsy;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic v1, input logic ir,
                         input logic ov, input logic or0, input logic or1);
        req0_in_valid  = v0;
        req1_in_valid  = v1;
        aes_in_ready   = ir;
        aes_out_valid  = ov;
        req0_out_ready = or0;
        req1_out_ready = or1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_in_block = BLK0;
        req1_in_block = BLK1;
        aes_out_block = BLKO;
        aes_fifo_empty = 1'b1;
        flush_req = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        //  v0 v1 ir ov o0 o1 | g aiv r0 r1 aor ov0 ov1 busy
        tbl[0]  = '{1,1,1,0,1,1, 0,1,1,0,0,0,0,0};
        tbl[1]  = '{1,1,1,0,1,1, 1,1,0,1,1,0,0,1};
        tbl[2]  = '{1,1,1,1,1,1, 0,1,1,0,1,1,0,1};
        tbl[3]  = '{0,1,1,1,1,1, 1,1,0,1,1,0,1,1};
        tbl[4]  = '{0,1,1,0,1,1, 1,1,0,1,1,0,0,1};
        tbl[5]  = '{0,1,0,1,0,1, 1,1,0,0,0,1,0,1};
        tbl[6]  = '{1,1,1,1,1,1, 1,1,0,1,1,1,0,1};
        tbl[7]  = '{1,1,1,1,1,0, 0,1,1,0,0,0,1,1};
        tbl[8]  = '{0,0,1,1,1,1, 0,0,0,0,1,0,1,1};
        tbl[9]  = '{0,0,1,1,1,1, 0,0,0,0,1,0,1,1};
        tbl[10] = '{0,0,1,1,1,1, 0,0,0,0,1,0,1,1};
        tbl[11] = '{0,0,1,1,1,0, 0,0,0,0,1,1,0,1};
        tbl[12] = '{0,0,1,1,1,1, 0,0,0,0,0,0,0,0};

        // Reset
        repeat (10) @(posedge clk);
        #1;
        chk("rst_aes_rst", aes_rst, 1);
        chk("rst_busy", busy, 1);
        chk("rst_flush_done", flush_done, 0);
        rst_n = 1'b1;
        tick();
        chk("run_aes_rst", aes_rst, 0);
        chk("run_busy", busy, 0);
        tick();
        chk("run_no_flush_done", fd_pulses, 0);

        // Table: arbitration, grant lock, in-order routing, head blocking
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v0, tbl[i].v1, tbl[i].ir, tbl[i].ov, tbl[i].or0, tbl[i].or1);
            chk($sformatf("v%0d_aiv", i), aes_in_valid, tbl[i].aiv);
            chk($sformatf("v%0d_rdy0", i), req0_in_ready, tbl[i].rdy0);
            chk($sformatf("v%0d_rdy1", i), req1_in_ready, tbl[i].rdy1);
            chk($sformatf("v%0d_aor", i), aes_out_ready, tbl[i].aor);
            chk($sformatf("v%0d_ov0", i), req0_out_valid, tbl[i].ov0);
            chk($sformatf("v%0d_ov1", i), req1_out_valid, tbl[i].ov1);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].bsy);
            if (tbl[i].aiv)
                chk($sformatf("v%0d_blk", i), aes_in_block, tbl[i].g ? BLK1 : BLK0);
            chk($sformatf("v%0d_oblk", i), tbl[i].ov1 ? req1_out_block : req0_out_block, BLKO);
            tick();
        end

        // Tag FIFO full: exactly 8 accepted, then one more after a single pop
        accepted = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1, 1, 1, 0, 1, 1);
            if (aes_in_valid && aes_in_ready) accepted++;
            tick();
        end
        chk("full_accepted", accepted, 8);
        drive(1, 1, 1, 0, 1, 1);
        chk("full_aiv", aes_in_valid, 0);
        chk("full_rdy0", req0_in_ready, 0);
        chk("full_rdy1", req1_in_ready, 0);
        drive(1, 1, 1, 1, 1, 1);
        chk("full_pop_aor", aes_out_ready, 1);
        tick();
        drive(1, 1, 1, 0, 1, 1);
        chk("refill_aiv", aes_in_valid, 1);
        tick();
        drive(1, 1, 1, 0, 1, 1);
        chk("refull_aiv", aes_in_valid, 0);
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 1, 1, 1, 1);
            tick();
        end
        drive(0, 0, 1, 0, 1, 1);
        chk("full_drained_busy", busy, 0);

        // Head tag 1 must not be bypassed by a ready requester 0
        drive(0, 1, 1, 0, 1, 1);
        chk("hb_push", req1_in_ready, 1);
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(0, 0, 1, 1, 1, 0);
            chk("hb_aor", aes_out_ready, 0);
            chk("hb_ov0", req0_out_valid, 0);
            chk("hb_ov1", req1_out_valid, 1);
            tick();
        end
        drive(0, 0, 1, 1, 1, 1);
        chk("hb_release", aes_out_ready, 1);
        tick();
        drive(0, 0, 1, 0, 1, 1);
        chk("hb_busy", busy, 0);

        // Flush with 3 blocks in flight (tags 0,1,0)
        for (int c = 0; c < 3; c++) begin
            drive(1, 1, 1, 0, 1, 1);
            tick();
        end
`ifdef AES_ARB_STATS_EN
        drive(0, 0, 1, 0, 1, 1);
        chk("stats_cnt0", blk_cnt0, 9);
        chk("stats_cnt1", blk_cnt1, 11);
`endif
        aes_fifo_empty = 1'b0;
        flush_req = 1'b1;
        drive(0, 0, 1, 0, 1, 1);
        tick();
        drive(1, 1, 1, 0, 1, 1);
        chk("drain_aiv", aes_in_valid, 0);
        chk("drain_rdy0", req0_in_ready, 0);
        chk("drain_rdy1", req1_in_ready, 0);
        for (int c = 0; c < 3; c++) begin
            drive(1, 1, 1, 1, 1, 1);
            chk($sformatf("drain_ov0_%0d", c), req0_out_valid, (c != 1));
            chk($sformatf("drain_ov1_%0d", c), req1_out_valid, (c == 1));
            chk($sformatf("drain_aiv_%0d", c), aes_in_valid, 0);
            tick();
        end
        drive(0, 0, 1, 0, 1, 1);
        chk("drain_wait_rst", aes_rst, 0);
        chk("drain_wait_busy", busy, 1);
        tick();
        aes_fifo_empty = 1'b1;
        drive(0, 0, 1, 0, 1, 1);
        chk("drain_wait_rst2", aes_rst, 0);
        tick();
        chk("flush_aes_rst", aes_rst, 1);
        chk("flush_busy", busy, 1);
        chk("flush_done_early", flush_done, 0);
        tick();
        chk("flush_aes_rst_low", aes_rst, 0);
        chk("flush_done_pulse", flush_done, 1);
`ifdef AES_ARB_STATS_EN
        chk("flush_cnt0", blk_cnt0, 0);
        chk("flush_cnt1", blk_cnt1, 0);
`endif
        tick();
        chk("flush_done_once", flush_done, 0);
        repeat (3) tick();
        chk("held_flush_ignored", busy, 0);
        chk("flush_pulses", fd_pulses, 1);

        // Release and reassert flush_req: a second flush runs
        flush_req = 1'b0;
        tick();
        flush_req = 1'b1;
        tick();
        chk("flush2_busy", busy, 1);
        tick();
        chk("flush2_aes_rst", aes_rst, 1);
        tick();
        chk("flush2_done", flush_done, 1);
        flush_req = 1'b0;
        repeat (2) tick();
        chk("flush2_pulses", fd_pulses, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
